// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and the parity helper for the UART.
// Both the TX and RX paths import this package.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Narrow data words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
// The head word reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             wr_ok, rd_ok;

    assign wr_ok = wr_en_i & ~full_q;
    assign rd_ok = rd_en_i & ~empty_q;

    always_comb begin
        count_d = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/uart_param.sv
// Parameterised UART: FIFO-buffered transmitter and receiver, each with its own
// bit-timing counter, plus one-cycle error pulses for bad received frames.
module uart_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_AW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic                 txd,
    input  logic                 wrreq,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 wrfull,
    input  logic                 rdreq,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 empty,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun
);
    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic          HAS_PARITY = (PARITY != PAR_NONE);

    logic                 tx_pop, tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_push, rx_full;

    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d, txd_q, txd_d, tx_tick;

    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_par_q, rx_par_d, rx_tick;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

    sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .wr_en_i(wrreq), .wr_data_i(write_data),
        .rd_en_i(tx_pop), .rd_data_o(tx_head), .full_o(wrfull), .empty_o(tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .wr_en_i(rx_push), .wr_data_i(rx_sh_q),
        .rd_en_i(rdreq), .rd_data_o(read_data), .full_o(rx_full), .empty_o(empty)
    );

    assign tx_tick = (tx_cnt_q == BIT_LAST);
    assign rx_tick = (rx_cnt_q == BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_par_d   = parity_bit(8'(tx_head), PARITY);
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
                txd_d      = tx_sh_q[0];
            end
            TX_DATA: if (tx_tick) begin
                if (tx_bit_q == DATA_LAST) begin
                    tx_bit_d   = '0;
                    tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
                    txd_d      = HAS_PARITY ? tx_par_q : 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = tx_sh_q >> 1;
                    txd_d    = tx_sh_q[1];
                end
            end
            TX_PARITY: if (tx_tick) begin
                tx_state_d = TX_STOP;
                tx_bit_d   = '0;
                txd_d      = 1'b1;
            end
            TX_STOP: if (tx_tick) begin
                if (tx_bit_q != STOP_LAST) begin
                    tx_bit_d = tx_bit_q + 3'd1;
                end else if (!tx_empty) begin
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_par_d   = parity_bit(8'(tx_head), PARITY);
                    txd_d      = 1'b0;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_push    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        if (rx_state_q != RX_IDLE) rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                // Mid-start re-check: a line already back high was only a glitch.
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                else rx_bit_d = rx_bit_q + 3'd1;
            end
            RX_PARITY: if (rx_tick) begin
                rx_par_d   = rx_s2_q;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                rx_state_d = RX_IDLE;
                if (!rx_s2_q) ferr_d = 1'b1;
                else if (HAS_PARITY && (rx_par_q != parity_bit(8'(rx_sh_q), PARITY))) perr_d = 1'b1;
                else if (rx_full) ovr_d = 1'b1;
                else rx_push = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign txd         = txd_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an even-parity instance (driven line or loopback) and an
// odd-parity instance in loopback, checked by RX scoreboards fed from a frame model.
module tb_uart_param;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = 11 * CPB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Even-parity instance
    logic       loop_en, drv_rxd, rxd_a, txd_a, wrreq_a, wrfull_a, rdreq_a, empty_a;
    logic       perr_a, ferr_a, ovr_a;
    logic [7:0] wdata_a, rdata_a;
    assign rxd_a = loop_en ? txd_a : drv_rxd;

    uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(4)) u_even (
        .clk(clk), .rst(rst), .rxd(rxd_a), .txd(txd_a), .wrreq(wrreq_a), .write_data(wdata_a),
        .wrfull(wrfull_a), .rdreq(rdreq_a), .read_data(rdata_a), .empty(empty_a),
        .parity_err(perr_a), .framing_err(ferr_a), .overrun(ovr_a)
    );

    // Odd-parity instance, permanently looped back
    logic       txd_b, wrreq_b, wrfull_b, rdreq_b, empty_b, perr_b, ferr_b, ovr_b;
    logic [7:0] wdata_b, rdata_b;

    uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(4)) u_odd (
        .clk(clk), .rst(rst), .rxd(txd_b), .txd(txd_b), .wrreq(wrreq_b), .write_data(wdata_b),
        .wrfull(wrfull_b), .rdreq(rdreq_b), .read_data(rdata_b), .empty(empty_b),
        .parity_err(perr_b), .framing_err(ferr_b), .overrun(ovr_b)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic       auto_rd_a, auto_rd_b;
    int         fe_a = 0, pe_a = 0, ov_a = 0, err_b = 0;
    int         exp_fe_a = 0, exp_pe_a = 0, exp_ov_a = 0;
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference frame: start, data LSB first, parity from a ones count, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit odd);
        logic [10:0] f;
        int          ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        f[10] = 1'b1;
        return f;
    endfunction

    // RX monitors: pop whenever a word is presented and compare with the expected queue.
    always @(negedge clk) begin
        cyc++;
        rdreq_a = 1'b0;
        rdreq_b = 1'b0;
        if (!rst && auto_rd_a && !empty_a) begin
            n_vec++;
            if (exp_a_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_a_unexpected got=%h", rdata_a);
            end else begin
                logic [7:0] e;
                e = exp_a_q.pop_front();
                if (rdata_a !== e) begin
                    n_err++;
                    $display("FAIL rx_a_data got=%h expected=%h", rdata_a, e);
                end
            end
            rdreq_a = 1'b1;
        end
        if (!rst && auto_rd_b && !empty_b) begin
            n_vec++;
            if (exp_b_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_b_unexpected got=%h", rdata_b);
            end else begin
                logic [7:0] e;
                e = exp_b_q.pop_front();
                if (rdata_b !== e) begin
                    n_err++;
                    $display("FAIL rx_b_data got=%h expected=%h", rdata_b, e);
                end
            end
            rdreq_b = 1'b1;
        end
        if (!rst) begin
            fe_a  += int'(ferr_a);
            pe_a  += int'(perr_a);
            ov_a  += int'(ovr_a);
            err_b += int'(perr_b) + int'(ferr_b) + int'(ovr_b);
        end
        if (cyc > 60000) begin
            $display("FAIL watchdog cycles=%0d limit=60000", cyc);
            $fatal(1);
        end
    end

    // Drives one frame on the even instance's line and records the outcome the rules predict.
    task automatic drive_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par);
        logic [10:0] f;
        f = frame_bits(d, 1'b0);
        if (bad_par)  f[9]  = ~f[9];
        if (bad_stop) f[10] = 1'b0;
        if (bad_stop)                      exp_fe_a++;
        else if (bad_par)                  exp_pe_a++;
        else if (exp_a_q.size() >= DEPTH)  exp_ov_a++;
        else                               exp_a_q.push_back(d);
        for (int b = 0; b < 11; b++) begin
            drv_rxd = f[b];
            repeat (CPB) @(negedge clk);
        end
        drv_rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_err_counts(input string tag);
        check({tag, "_framing"}, fe_a, exp_fe_a);
        check({tag, "_parity"},  pe_a, exp_pe_a);
        check({tag, "_overrun"}, ov_a, exp_ov_a);
    endtask

    initial begin : main
        logic [7:0]  d;
        logic [10:0] bits;
        logic [7:0]  b_bytes [3];
        int          bad, t, ts, n_acc, k;
        b_bytes = '{8'hA5, 8'h3C, 8'hFF};
        rst = 1'b1; loop_en = 1'b0; drv_rxd = 1'b1;
        wrreq_a = 1'b0; wdata_a = '0; wrreq_b = 1'b0; wdata_b = '0;
        auto_rd_a = 1'b1; auto_rd_b = 1'b1;
        repeat (4) @(negedge clk);

        check("rst_txd", txd_a, 1);
        check("rst_wrfull", wrfull_a, 0);
        check("rst_empty", empty_a, 1);
        check("rst_read_data", rdata_a, 0);
        check("rst_err_pulses", {perr_a, ferr_a, ovr_a}, 0);
        check("rst_txd_b", txd_b, 1);
        rst = 1'b0;
        @(negedge clk);

        // Exact TX frame for 0x55 with even parity, looped back into RX
        loop_en = 1'b1;
        wrreq_a = 1'b1; wdata_a = 8'h55; exp_a_q.push_back(8'h55);
        @(negedge clk);
        wrreq_a = 1'b0;
        @(negedge clk);
        check("tx_start_latency", txd_a, 0);
        bits = frame_bits(8'h55, 1'b0);
        for (int b = 0; b < 11; b++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (txd_a !== bits[b]) bad++;
                @(negedge clk);
            end
            check($sformatf("tx_0x55_bit%0d_wrong_cycles", b), bad, 0);
        end
        check("tx_idle_after_frame", txd_a, 1);
        repeat (20) @(negedge clk);

        // Random back-to-back loopback bytes
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            wrreq_a = 1'b1; wdata_a = d; exp_a_q.push_back(d);
            @(negedge clk);
        end
        wrreq_a = 1'b0;
        repeat (5 * FRAME + 40) @(negedge clk);
        check("loop_a_drained", exp_a_q.size(), 0);

        // Odd-parity loopback with no inter-frame gap
        t = 0; ts = -1;
        for (int i = 0; i < 3; i++) begin
            wrreq_b = 1'b1; wdata_b = b_bytes[i]; exp_b_q.push_back(b_bytes[i]);
            @(negedge clk); t++;
            if (ts < 0 && txd_b == 1'b0) ts = t;
        end
        wrreq_b = 1'b0;
        check("b_start_seen", (ts >= 1 && ts <= 2), 1);
        while (t < ts + 530) begin
            @(negedge clk); t++;
            if (t == ts + 175 || t == ts + 351) check($sformatf("b_stop_before_t%0d", t - ts), txd_b, 1);
            if (t == ts + 176 || t == ts + 352) check($sformatf("b_nogap_start_t%0d", t - ts), txd_b, 0);
            if (t == ts + 528) check("b_idle_after_3", txd_b, 1);
        end
        repeat (30) @(negedge clk);
        check("loop_b_drained", exp_b_q.size(), 0);
        check("loop_b_no_errors", err_b, 0);

        // Framing error then a good frame, then a parity error
        loop_en = 1'b0;
        drive_frame(8'h81, 1'b1, 1'b0);
        check("framing_empty_stays", empty_a, 1);
        check("framing_pulse_count", fe_a, exp_fe_a);
        drive_frame(8'h42, 1'b0, 1'b0);
        drive_frame(8'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 3);
            drive_frame(8'($urandom), k == 2, k == 3);
        end
        repeat (4) @(negedge clk);
        check_err_counts("driven");
        check("driven_drained", exp_a_q.size(), 0);

        // Short glitch on an idle line
        drv_rxd = 1'b0;
        repeat (4) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("glitch_empty", empty_a, 1);
        check_err_counts("glitch");

        // Overrun: 17 frames without reading
        auto_rd_a = 1'b0;
        for (int i = 0; i <= 16; i++) drive_frame(8'(i), 1'b0, 1'b0);
        check("ovr_fifo_holding", empty_a, 0);
        check_err_counts("overrun");
        auto_rd_a = 1'b1;
        repeat (40) @(negedge clk);
        check("ovr_drained", exp_a_q.size(), 0);

        // TX FIFO fill while the transmitter is busy
        loop_en = 1'b1;
        d = 8'($urandom);
        wrreq_a = 1'b1; wdata_a = d; exp_a_q.push_back(d);
        @(negedge clk);
        wrreq_a = 1'b0;
        repeat (4) @(negedge clk);
        n_acc = 0;
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            wrreq_a = 1'b1; wdata_a = d;
            if (n_acc < DEPTH) begin
                exp_a_q.push_back(d);
                n_acc++;
            end
            @(negedge clk);
            check($sformatf("wrfull_after_write%0d", i + 1), wrfull_a, (n_acc == DEPTH));
        end
        wrreq_a = 1'b0;
        repeat (17 * FRAME + 60) @(negedge clk);
        check("wrfull_burst_drained", exp_a_q.size(), 0);
        check_err_counts("burst");

        // Reset in the middle of a looped-back frame
        wrreq_a = 1'b1; wdata_a = 8'($urandom);
        @(negedge clk);
        wrreq_a = 1'b0;
        repeat (3 * CPB + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", txd_a, 1);
        check("midrst_empty", empty_a, 1);
        check("midrst_wrfull", wrfull_a, 0);
        rst = 1'b0;
        bad = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (txd_a !== 1'b1) bad++;
        end
        check("midrst_txd_stays_high", bad, 0);
        check("midrst_empty_after", empty_a, 1);
        check_err_counts("midrst");
        check("final_b_no_errors", err_b, 0);
        check("final_a_queue", exp_a_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
